// File: rtl/cv32e40p_trace_buffer.sv
// Multi-channel instruction trace buffer.
//
// Collects {pc, instr, channel, timestamp} records from NUM_CH trace sources
// into a DEPTH-entry circular store and presents the oldest record on a
// valid/ready drain port.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   enable_i            capture enable
//   mode_i              full policy: 0 = stall sources, 1 = overwrite oldest
//   clear_i             synchronous flush (records, level, drops, arbiter)
//   ch_valid_i/ch_pc_i/ch_instr_i/ch_ready_o
//                       per-channel source handshake, pc/instr packed 32 bits
//                       per channel (channel k at bits [32k +: 32])
//   rd_valid_o/rd_ready_i
//                       drain handshake
//   rd_pc_o/rd_instr_o/rd_ch_o/rd_ts_o
//                       oldest record (zero while empty)
//   level_o             occupied slots
//   drop_cnt_o          records discarded by overwrite, saturating
module cv32e40p_trace_buffer #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          enable_i,
  input  logic                                          mode_i,
  input  logic                                          clear_i,
  input  logic [NUM_CH-1:0]                             ch_valid_i,
  input  logic [NUM_CH*32-1:0]                          ch_pc_i,
  input  logic [NUM_CH*32-1:0]                          ch_instr_i,
  output logic [NUM_CH-1:0]                             ch_ready_o,
  output logic                                          rd_valid_o,
  input  logic                                          rd_ready_i,
  output logic [31:0]                                   rd_pc_o,
  output logic [31:0]                                   rd_instr_o,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch_o,
  output logic [TS_W-1:0]                               rd_ts_o,
  output logic [$clog2(DEPTH):0]                        level_o,
  output logic [15:0]                                   drop_cnt_o
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam logic [CH_W:0] NCH      = (CH_W+1)'(NUM_CH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] k);
    return (({1'b0, k} + 1'b1) == NCH) ? '0 : k + 1'b1;
  endfunction

  logic [TS_W-1:0] ts;
  logic [CH_W-1:0] rr_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     level;
  logic [15:0]     drop_cnt;

  logic [31:0]     pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [CH_W-1:0] ch_mem    [DEPTH];
  logic [TS_W-1:0] ts_mem    [DEPTH];

  logic [CH_W:0]   cand;
  logic            gnt_vld;
  logic [CH_W-1:0] gnt_idx;
  logic [31:0]     pc_in;
  logic [31:0]     instr_in;
  logic            full;
  logic            can_push;
  logic            push;
  logic            pop;

  // Round-robin arbitration: scan channels starting at rr_ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (cand >= NCH) cand = cand - NCH;
      if (!gnt_vld && ch_valid_i[cand[CH_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[CH_W-1:0];
      end
    end
  end

  always_comb begin
    pc_in    = '0;
    instr_in = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == CH_W'(i)) begin
        pc_in    = ch_pc_i[i*32 +: 32];
        instr_in = ch_instr_i[i*32 +: 32];
      end
    end
  end

  assign full       = (level == FULL_LVL);
  // Reset gates acceptance combinationally so sources see no ready while held.
  assign can_push   = ~rst_i & enable_i & ~clear_i & (mode_i | ~full);
  assign push       = can_push & gnt_vld;
  assign ch_ready_o = push ? (NUM_CH'(1) << gnt_idx) : '0;
  assign rd_valid_o = (level != '0);
  assign pop        = rd_valid_o & rd_ready_i & ~clear_i;

  // Record store: data only, no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]    <= pc_in;
      instr_mem[wr_ptr] <= instr_in;
      ch_mem[wr_ptr]    <= gnt_idx;
      ts_mem[wr_ptr]    <= ts;
    end
  end

  // Control state. Overwrite when full advances the read pointer so the
  // oldest record is discarded and the level stays at DEPTH.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts       <= '0;
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (clear_i) begin
        rr_ptr   <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        drop_cnt <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          rr_ptr <= rr_next(gnt_idx);
        end
        if (pop || (push && full)) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop && !full) level <= level + 1'b1;
        else if (pop && !push)     level <= level - 1'b1;
        if (push && full && !pop)  drop_cnt <= sat_inc16(drop_cnt);
      end
    end
  end

  // Output stage: oldest record, forced to zero while empty.
  assign rd_pc_o    = rd_valid_o ? pc_mem[rd_ptr]    : '0;
  assign rd_instr_o = rd_valid_o ? instr_mem[rd_ptr] : '0;
  assign rd_ch_o    = rd_valid_o ? ch_mem[rd_ptr]    : '0;
  assign rd_ts_o    = rd_valid_o ? ts_mem[rd_ptr]    : '0;
  assign level_o    = level;
  assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_cv32e40p_trace_buffer.sv
// Directed testbench for cv32e40p_trace_buffer (NUM_CH=2, DEPTH=4, TS_W=4).
module tb_cv32e40p_trace_buffer;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;
  localparam int TS_W   = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   enable;
  logic                   mode;
  logic                   clear;
  logic [NUM_CH-1:0]      ch_valid;
  logic [NUM_CH*32-1:0]   ch_pc;
  logic [NUM_CH*32-1:0]   ch_instr;
  logic [NUM_CH-1:0]      ch_ready;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [31:0]            rd_pc;
  logic [31:0]            rd_instr;
  logic [0:0]             rd_ch;
  logic [TS_W-1:0]        rd_ts;
  logic [2:0]             level;
  logic [15:0]            drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [TS_W-1:0] ts_model;

  cv32e40p_trace_buffer #(
    .NUM_CH(NUM_CH),
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .enable_i  (enable),
    .mode_i    (mode),
    .clear_i   (clear),
    .ch_valid_i(ch_valid),
    .ch_pc_i   (ch_pc),
    .ch_instr_i(ch_instr),
    .ch_ready_o(ch_ready),
    .rd_valid_o(rd_valid),
    .rd_ready_i(rd_ready),
    .rd_pc_o   (rd_pc),
    .rd_instr_o(rd_instr),
    .rd_ch_o   (rd_ch),
    .rd_ts_o   (rd_ts),
    .level_o   (level),
    .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  // Independent timestamp reference: counts edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) ts_model <= '0;
    else     ts_model <= ts_model + 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 1'b0; clear = 1'b0;
    ch_valid = '0; ch_pc = '0; ch_instr = '0; rd_ready = 1'b0;
    #1;
    check("rst_level",    32'(level),    32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_ready",    32'(ch_ready), 32'd0);
    check("rst_drop",     32'(drop_cnt), 32'd0);
    check("rst_rd_pc",    rd_pc,         32'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;

    // A: mode 0, both channels valid, no drain -> alternating grants, then stall
    enable = 1'b1; mode = 1'b0; ch_valid = 2'b11;
    ch_pc = {32'h200, 32'h100}; ch_instr = {32'hB0, 32'hA0};
    for (int i = 0; i < 4; i++) begin
      #1;
      check("A_grant", 32'(ch_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end
    #1;
    check("A_full_stall", 32'(ch_ready), 32'd0);
    check("A_level",      32'(level),    32'd4);
    check("A_drop",       32'(drop_cnt), 32'd0);
    check("A_rd_instr",   rd_instr,      32'hA0);
    ch_valid = '0; rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("A_pop_pc", rd_pc,        (i % 2 == 0) ? 32'h100 : 32'h200);
      check("A_pop_ch", 32'(rd_ch),   (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
    end
    check("A_empty_valid", 32'(rd_valid), 32'd0);
    tick();
    check("A_pop_empty_noop", 32'(level), 32'd0);
    rd_ready = 1'b0;

    // B: mode 1 overwrite of oldest when full
    mode = 1'b1; ch_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      ch_pc[31:0] = 32'h100 + 32'(i);
      tick();
    end
    check("B_level_full", 32'(level), 32'd4);
    ch_valid = '0;
    tick();
    check("B_hold", rd_pc, 32'h100);
    ch_valid = 2'b01; ch_pc[31:0] = 32'h104;
    #1;
    check("B_ready_when_full", 32'(ch_ready), 32'd1);
    tick();
    ch_valid = '0;
    check("B_ovr_pc",    rd_pc,         32'h101);
    check("B_ovr_level", 32'(level),    32'd4);
    check("B_ovr_drop",  32'(drop_cnt), 32'd1);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("B_drain_pc", rd_pc, 32'h101 + 32'(i));
      tick();
    end
    rd_ready = 1'b0;
    check("B_drained", 32'(level), 32'd0);

    // C: full, simultaneous push and pop
    ch_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      ch_pc[31:0] = 32'h100 + 32'(i);
      tick();
    end
    ch_pc[31:0] = 32'h105; rd_ready = 1'b1;
    #1;
    check("C_popped_pc", rd_pc, 32'h100);
    tick();
    ch_valid = '0; rd_ready = 1'b0;
    check("C_level", 32'(level),    32'd4);
    check("C_drop",  32'(drop_cnt), 32'd1);
    check("C_next",  rd_pc,         32'h101);
    mode = 1'b0; ch_valid = 2'b01;
    #1;
    check("C_mode0_full_stall", 32'(ch_ready), 32'd0);
    ch_valid = '0;

    // D: clear flushes records, drops and arbitration pointer
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("D_clr_level", 32'(level),    32'd0);
    check("D_clr_drop",  32'(drop_cnt), 32'd0);
    ch_valid = 2'b11; ch_pc = {32'h301, 32'h300};
    for (int i = 0; i < 3; i++) tick();
    check("D_level3", 32'(level), 32'd3);
    clear = 1'b1; rd_ready = 1'b1;
    #1;
    check("D_ready_in_clear", 32'(ch_ready), 32'd0);
    tick();
    clear = 1'b0; rd_ready = 1'b0; ch_valid = '0;
    check("D_level0", 32'(level),    32'd0);
    check("D_valid0", 32'(rd_valid), 32'd0);
    ch_valid = 2'b11; ch_pc = {32'h222, 32'h111};
    #1;
    check("D_arb_reset", 32'(ch_ready), 32'd1);
    tick();
    ch_valid = '0;
    check("D_push_level", 32'(level), 32'd1);
    check("D_push_pc",    rd_pc,      32'h111);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;

    // E: timestamp wrap at 15 -> 0
    for (int g = 0; g < 20 && ts_model != 4'd15; g++) tick();
    ch_valid = 2'b01; ch_pc[31:0] = 32'h400;
    tick();
    ch_pc[31:0] = 32'h401;
    tick();
    ch_valid = '0;
    check("E_ts15", 32'(rd_ts), 32'd15);
    check("E_pc0",  rd_pc,      32'h400);
    rd_ready = 1'b1;
    tick();
    check("E_ts0", 32'(rd_ts), 32'd0);
    check("E_pc1", rd_pc,      32'h401);
    tick();
    rd_ready = 1'b0;

    // F: asynchronous reset mid-operation with level 3
    mode = 1'b1; ch_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      ch_pc[31:0] = 32'h500 + 32'(i);
      tick();
    end
    ch_valid = '0; rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("F_level3", 32'(level),    32'd3);
    check("F_drop1",  32'(drop_cnt), 32'd1);
    ch_valid = 2'b01;
    #2;
    rst = 1'b1;
    #1;
    check("F_rst_level", 32'(level),    32'd0);
    check("F_rst_valid", 32'(rd_valid), 32'd0);
    check("F_rst_ready", 32'(ch_ready), 32'd0);
    check("F_rst_drop",  32'(drop_cnt), 32'd0);
    check("F_rst_pc",    rd_pc,         32'd0);
    check("F_rst_ts",    32'(rd_ts),    32'd0);
    @(negedge clk);
    rst = 1'b0; ch_pc[31:0] = 32'h600;
    tick();
    ch_valid = '0;
    check("F_first_valid", 32'(rd_valid), 32'd1);
    check("F_first_pc",    rd_pc,         32'h600);
    check("F_first_ts",    32'(rd_ts),    32'd0);
    check("F_first_level", 32'(level),    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
